// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a 32-bit hex display word across 8 digit slots for the downstream
// seven-segment decoder, with frame-synchronous word updates, per-digit blanking and leading-zero suppression.
module seven_seg_scanner #(
   parameter int DIV   = 100000,
   parameter int DIV_W = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic [7:0]  blank_mask,
   input  logic        lz_suppress,
   output logic [3:0]  num,
   output logic [2:0]  sel,
   output logic        digit_on,
   output logic        frame_done,
   output logic        upd_pending
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] pre_q, pre_d;
   logic [2:0]       sel_q, sel_d;
   logic [31:0]      active_q, active_d;
   logic [31:0]      pending_q, pending_d;
   logic             upd_q, upd_d;
   logic             fd_q, fd_d;
   logic             tick;
   logic             boundary;
   logic [7:0]       lzb;

   always_comb begin
      tick      = en && (pre_q == LAST);
      boundary  = tick && (sel_q == 3'd7);
      pre_d     = pre_q;
      sel_d     = sel_q;
      active_d  = active_q;
      pending_d = pending_q;
      upd_d     = upd_q;
      fd_d      = boundary;

      if (en) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
      if (tick) begin
         sel_d = sel_q + 3'd1;
      end

      // A write landing on the wrap goes straight to the active word; the older pending word is dropped.
      if (boundary) begin
         if (wr_en) begin
            active_d = wr_data;
         end else if (upd_q) begin
            active_d = pending_q;
         end
         upd_d = 1'b0;
      end else if (wr_en) begin
         pending_d = wr_data;
         upd_d     = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q     <= '0;
         sel_q     <= '0;
         active_q  <= '0;
         pending_q <= '0;
         upd_q     <= 1'b0;
         fd_q      <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         sel_q     <= sel_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         upd_q     <= upd_d;
         fd_q      <= fd_d;
      end
   end

   // lzb[k]: nibbles k..7 are all zero; digit 0 is never suppressed so zero shows as "0".
   always_comb begin
      lzb = '0;
      for (int k = 1; k < 8; k++) begin
         lzb[k] = lz_suppress && ((active_q >> (4 * k)) == 32'd0);
      end
   end

   // rst_n gates digit_on so the display stays dark for the whole reset period.
   assign num         = active_q[{sel_q, 2'b00} +: 4];
   assign sel         = sel_q;
   assign digit_on    = rst_n & en & ~blank_mask[sel_q] & ~lzb[sel_q];
   assign frame_done  = fd_q;
   assign upd_pending = upd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a time-stamped expectation table feeds a scoreboard
// that compares the DUT outputs on every falling edge.
module tb_seven_seg_scanner;

   localparam int DIV   = 4;
   localparam int DIV_W = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = 32'h0;
   logic [7:0]  blank_mask = 8'h00;
   logic        lz_suppress = 1'b0;
   logic [3:0]  num;
   logic [2:0]  sel;
   logic        digit_on;
   logic        frame_done;
   logic        upd_pending;

   typedef struct packed {
      int         cyc;
      logic [3:0] ph;
      logic [2:0] sel;
      logic [3:0] num;
      logic       on;
      logic       fd;
      logic       up;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   seven_seg_scanner #(.DIV(DIV), .DIV_W(DIV_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .blank_mask  (blank_mask),
      .lz_suppress (lz_suppress),
      .num         (num),
      .sel         (sel),
      .digit_on    (digit_on),
      .frame_done  (frame_done),
      .upd_pending (upd_pending)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      assert (DIV >= 2) else $fatal(1, "FAIL param_div DIV=%0d must be >= 2", DIV);
   end

   // driver tasks
   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_word(input int c, input logic [31:0] d);
      goto(c);
      wr_en   = 1'b1;
      wr_data = d;
      goto(c + 1);
      wr_en   = 1'b0;
   endtask

   task automatic push_one(input int c, input int ph, input logic [2:0] s, input logic [3:0] n,
                           input logic on, input logic fd, input logic up);
      exp_t e;
      e.cyc = c;
      e.ph  = 4'(ph);
      e.sel = s;
      e.num = n;
      e.on  = on;
      e.fd  = fd;
      e.up  = up;
      exp_q.push_back(e);
   endtask

   // One expectation per cycle t0..t1 of a scan starting at base: digit t/4, frame pulse on t%32==0.
   task automatic push_span(input int base, input int t0, input int t1, input logic [31:0] word,
                            input logic [7:0] on_mask, input logic up, input logic fd_wrap, input int ph);
      for (int t = t0; t <= t1; t++) begin
         logic [2:0] s;
         s = 3'((t / 4) % 8);
         push_one(base + t, ph, s, word[{s, 2'b00} +: 4], on_mask[s], fd_wrap && (t % 32 == 0), up);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         n_checks++;
         if (e.cyc != cyc) begin
            $display("FAIL stale_entry ph=%0d exp_cyc=%0d now=%0d", e.ph, e.cyc, cyc);
         end else if ({sel, num, digit_on, frame_done, upd_pending} !== {e.sel, e.num, e.on, e.fd, e.up}) begin
            $display("FAIL ph%0d cyc=%0d got sel=%0d num=%h on=%b fd=%b up=%b want sel=%0d num=%h on=%b fd=%b up=%b",
                     e.ph, cyc, sel, num, digit_on, frame_done, upd_pending, e.sel, e.num, e.on, e.fd, e.up);
         end else begin
            n_pass++;
         end
      end
   end

   initial begin
      // expectation table (frame bases: 7, 71, 103, 135, 167, 199, 231, 263, 305, 318)
      for (int c = 1; c <= 6; c++) push_one(c, 0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
      push_span(7, 0, 0, 32'h0, 8'hFF, 1'b0, 1'b0, 1);
      push_span(7, 1, 31, 32'h0, 8'hFF, 1'b1, 1'b0, 1);
      push_span(7, 32, 63, 32'h76543210, 8'hFF, 1'b0, 1'b1, 1);
      push_span(71, 0, 12, 32'h76543210, 8'hFF, 1'b0, 1'b1, 2);
      push_span(71, 13, 31, 32'h76543210, 8'hFF, 1'b1, 1'b1, 2);
      push_span(103, 0, 31, 32'hFEDCBA98, 8'hFF, 1'b0, 1'b1, 2);
      push_span(135, 0, 5, 32'h0000ABCD, 8'hFF, 1'b0, 1'b1, 3);
      push_span(135, 6, 31, 32'h0000ABCD, 8'hFF, 1'b1, 1'b1, 3);
      push_span(167, 0, 3, 32'h00000305, 8'h07, 1'b0, 1'b1, 4);
      push_span(167, 4, 31, 32'h00000305, 8'h07, 1'b1, 1'b1, 4);
      push_span(199, 0, 31, 32'h0, 8'h01, 1'b0, 1'b1, 4);
      push_span(231, 0, 2, 32'h0, 8'h7E, 1'b0, 1'b1, 5);
      push_span(231, 3, 31, 32'h0, 8'h7E, 1'b1, 1'b1, 5);
      push_span(263, 0, 19, 32'h13579BDF, 8'hFF, 1'b0, 1'b1, 6);
      for (int c = 283; c <= 292; c++) push_one(c, 6, 3'd5, 4'h5, 1'b0, 1'b0, 1'b0);
      push_span(273, 20, 31, 32'h13579BDF, 8'hFF, 1'b0, 1'b1, 6);
      push_span(305, 0, 5, 32'h13579BDF, 8'hFF, 1'b0, 1'b1, 7);
      push_span(305, 6, 9, 32'h13579BDF, 8'hFF, 1'b1, 1'b1, 7);
      for (int c = 315; c <= 317; c++) push_one(c, 7, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
      push_span(318, 0, 31, 32'h0, 8'hFF, 1'b0, 1'b0, 7);
      push_span(318, 32, 32, 32'h0, 8'hFF, 1'b0, 1'b1, 7);

      // writes during reset must be ignored
      write_word(2, 32'hFFFFFFFF);
      write_word(4, 32'hFFFFFFFF);

      goto(7);
      rst_n = 1'b1;
      write_word(7, 32'h76543210);
      write_word(83, 32'hFEDCBA98);   // sel=3 of frame 71
      write_word(134, 32'h0000ABCD);  // tick cycle with sel=7
      write_word(140, 32'h00000305);
      goto(167);
      lz_suppress = 1'b1;
      write_word(170, 32'h00000000);
      goto(231);
      lz_suppress = 1'b0;
      blank_mask  = 8'h81;
      write_word(233, 32'h13579BDF);
      goto(263);
      blank_mask = 8'h00;
      goto(283);
      en = 1'b0;
      goto(293);
      en = 1'b1;
      write_word(310, 32'h22222222);
      goto(315);
      rst_n = 1'b0;
      goto(318);
      rst_n = 1'b1;
      goto(352);

      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
      end else begin
         n_pass++;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
